i2c_codec_responder: RTL and testbench



---
 rtl/i2c_codec_responder_if.sv | 25 ++
 rtl/i2c_codec_responder.sv | 215 +++++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_codec_responder_if.sv
// I2C responder bus bundle: the two I2C lines, the ACK pull-down, the
// register-write report and the shadow-register read port.
`timescale 1ns/1ps
interface i2c_codec_responder_if;
  logic       i_scl;
  logic       i_sda;
  logic       o_sda_pull;
  logic       o_wr_valid;
  logic [6:0] o_wr_addr;
  logic [8:0] o_wr_data;
  logic       o_busy;
  logic       o_err;
  logic [3:0] i_rd_addr;
  logic [8:0] o_rd_data;

  modport slave (
    input  i_scl, i_sda, i_rd_addr,
    output o_sda_pull, o_wr_valid, o_wr_addr, o_wr_data, o_busy, o_err, o_rd_data
  );

  modport master (
    output i_scl, i_sda, i_rd_addr,
    input  o_sda_pull, o_wr_valid, o_wr_addr, o_wr_data, o_busy, o_err, o_rd_data
  );
endinterface

// File: rtl/i2c_codec_responder.sv
// WM8731-style I2C target: oversamples SCL/SDA, decodes START/STOP,
// ACKs 3-byte write frames to DEV_ADDR and reports each write as a 7-bit
// register address plus 9-bit value.
// Optional feature macro: I2C_RESP_REGFILE_EN adds an 11-entry shadow
// register file readable through i_rd_addr/o_rd_data.
`timescale 1ns/1ps
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  i2c_codec_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_A, BYTE1, ACK_1, BYTE2, ACK_2, IGNORE
  } state_t;

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] scl_sync_p0, sda_sync_p0;
  logic                   scl_h_p1, sda_h_p1;
  logic [SYNC_STAGES:0]   vld_p0;
  logic                   scl_s, sda_s, settled;
  logic                   scl_rise, scl_fall, start_c, stop_c;
  logic [2:0]             cnt, cnt_nxt;
  logic [7:0]             sreg, sreg_nxt, byte1, byte1_nxt, byte_c;
  logic                   ack_on, ack_on_nxt, arm, arm_nxt, busy_nxt;
  logic                   frame_open, commit_c, err_c, commit_p1, err_p1;
  logic [6:0]             pend_addr_p1;
  logic [8:0]             pend_data_p1;

  // Synchronizer plus history stage; vld_p0 marks when the chain holds real
  // line values again after reset so no false START/STOP is decoded.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync_p0 <= '1;
      sda_sync_p0 <= '1;
      scl_h_p1    <= 1'b1;
      sda_h_p1    <= 1'b1;
      vld_p0      <= '0;
    end else begin
      scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], bus.i_scl};
      sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], bus.i_sda};
      scl_h_p1    <= scl_sync_p0[SYNC_STAGES-1];
      sda_h_p1    <= sda_sync_p0[SYNC_STAGES-1];
      vld_p0      <= {vld_p0[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign scl_s    = scl_sync_p0[SYNC_STAGES-1];
  assign sda_s    = sda_sync_p0[SYNC_STAGES-1];
  assign settled  = vld_p0[SYNC_STAGES];
  assign scl_rise = settled &  scl_s & ~scl_h_p1;
  assign scl_fall = settled & ~scl_s &  scl_h_p1;
  assign start_c  = settled & scl_s & scl_h_p1 &  sda_h_p1 & ~sda_s;
  assign stop_c   = settled & scl_s & scl_h_p1 & ~sda_h_p1 &  sda_s;
  assign byte_c   = {sreg[6:0], sda_s};
  assign frame_open = (state == BYTE1) || (state == ACK_1) ||
                      (state == BYTE2) || (state == ACK_2);

  // Frame FSM: bit shifting, address match, ACK phasing and commit/error decisions.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sreg_nxt   = sreg;
    byte1_nxt  = byte1;
    ack_on_nxt = ack_on;
    arm_nxt    = arm;
    busy_nxt   = bus.o_busy;
    commit_c   = 1'b0;
    err_c      = 1'b0;
    if (start_c) begin
      err_c      = frame_open;
      state_nxt  = ADDR;
      cnt_nxt    = 3'd0;
      busy_nxt   = 1'b1;
      ack_on_nxt = 1'b0;
      arm_nxt    = 1'b0;
    end else if (stop_c) begin
      err_c      = frame_open;
      state_nxt  = IDLE;
      busy_nxt   = 1'b0;
      ack_on_nxt = 1'b0;
      arm_nxt    = 1'b0;
    end else begin
      case (state)
        ADDR, BYTE1, BYTE2, IGNORE: begin
          if (scl_rise) begin
            sreg_nxt = byte_c;
            cnt_nxt  = cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (state == ADDR) begin
                if (byte_c[7:1] != DEV_ADDR) begin
                  state_nxt = IGNORE;
                end else if (byte_c[0]) begin
                  // Reads are not supported by the codec: NACK and flag it.
                  state_nxt = IGNORE;
                  err_c     = 1'b1;
                end else begin
                  state_nxt = ACK_A;
                end
              end else if (state == BYTE1) begin
                byte1_nxt = byte_c;
                state_nxt = ACK_1;
              end else if (state == BYTE2) begin
                state_nxt = ACK_2;
              end else if (arm) begin
                // First surplus byte after a committed write.
                err_c   = 1'b1;
                arm_nxt = 1'b0;
              end
            end
          end
        end
        ACK_A, ACK_1, ACK_2: begin
          if (scl_fall) begin
            if (!ack_on) begin
              ack_on_nxt = 1'b1;
            end else begin
              ack_on_nxt = 1'b0;
              cnt_nxt    = 3'd0;
              if (state == ACK_A) begin
                state_nxt = BYTE1;
              end else if (state == ACK_1) begin
                state_nxt = BYTE2;
              end else begin
                state_nxt = IGNORE;
                commit_c  = 1'b1;
                arm_nxt   = 1'b1;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  // FSM control registers and decision-stage pulses.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      ack_on     <= 1'b0;
      arm        <= 1'b0;
      bus.o_busy <= 1'b0;
      commit_p1  <= 1'b0;
      err_p1     <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      ack_on     <= ack_on_nxt;
      arm        <= arm_nxt;
      bus.o_busy <= busy_nxt;
      commit_p1  <= commit_c;
      err_p1     <= err_c;
    end
  end

  // Shift/byte data and the pending write captured as ACK_2 is left.
  always_ff @(posedge i_clk) begin
    sreg  <= sreg_nxt;
    byte1 <= byte1_nxt;
    if (commit_c) begin
      pend_addr_p1 <= byte1[7:1];
      pend_data_p1 <= {byte1[0], sreg};
    end
  end

  // Output stage: ACK pull-down, write report and error pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_sda_pull <= 1'b0;
      bus.o_wr_valid <= 1'b0;
      bus.o_err      <= 1'b0;
      bus.o_wr_addr  <= '0;
      bus.o_wr_data  <= '0;
    end else begin
      bus.o_sda_pull <= ack_on;
      bus.o_wr_valid <= commit_p1;
      bus.o_err      <= err_p1;
      if (commit_p1) begin
        bus.o_wr_addr <= pend_addr_p1;
        bus.o_wr_data <= pend_data_p1;
      end
    end
  end

`ifdef I2C_RESP_REGFILE_EN
  logic [8:0] regs [0:10];

  // Shadow register file: updated with o_wr_valid, cleared by a write to R15.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i <= 10; i++) regs[i] <= '0;
      bus.o_rd_data <= '0;
    end else begin
      if (commit_p1) begin
        if (pend_addr_p1 == 7'd15) begin
          for (int i = 0; i <= 10; i++) regs[i] <= '0;
        end else if (pend_addr_p1 <= 7'd10) begin
          regs[pend_addr_p1[3:0]] <= pend_data_p1;
        end
      end
      bus.o_rd_data <= (bus.i_rd_addr <= 4'd10) ? regs[bus.i_rd_addr] : 9'd0;
    end
  end
`else
  logic unused_rd_addr;
  assign unused_rd_addr = ^bus.i_rd_addr;
  assign bus.o_rd_data  = '0;
`endif

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: a bit-banged I2C master drives directed
// and random frames; a frame-level model predicts ACKs, write reports,
// error pulses and shadow-register contents; a monitor process checks
// every o_wr_valid / o_err pulse against the expected-event queue.
`timescale 1ns/1ps
module tb_i2c_codec_responder;

  localparam int Q = 6;  // i_clk cycles per quarter SCL period

  typedef struct {
    bit         is_err;
    logic [6:0] addr;
    logic [8:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sda_m;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   pull_rises = 0;
  bit   prev_v, prev_e, prev_p;
  ev_t  exp_q[$];
  ev_t  mon_ev;
  logic [7:0] fb [0:7];
  logic [8:0] mreg [0:10];

  i2c_codec_responder_if bus();

  assign bus.i_sda = sda_m & ~bus.o_sda_pull;

  i2c_codec_responder dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every reported event must match the head of the expected queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.o_wr_valid || bus.o_err) begin
        check("valid_err_overlap", {31'd0, bus.o_wr_valid & bus.o_err}, 32'd0);
        check("pulse_width", {31'd0, (bus.o_wr_valid & prev_v) | (bus.o_err & prev_e)}, 32'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_event: got valid=%0d err=%0d, expected no event",
                   bus.o_wr_valid, bus.o_err);
        end else begin
          mon_ev = exp_q.pop_front();
          check("event_kind_err", {31'd0, bus.o_err}, {31'd0, mon_ev.is_err});
          if (!mon_ev.is_err) begin
            check("wr_addr", {25'd0, bus.o_wr_addr}, {25'd0, mon_ev.addr});
            check("wr_data", {23'd0, bus.o_wr_data}, {23'd0, mon_ev.data});
          end
        end
      end
      if (bus.o_sda_pull && !prev_p) pull_rises++;
    end
    prev_v = bus.o_wr_valid;
    prev_e = bus.o_err;
    prev_p = bus.o_sda_pull;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic qwait();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    if (!bus.i_scl) begin
      sda_m = 1'b1; qwait();
      bus.i_scl = 1'b1; qwait();
    end
    sda_m = 1'b0; qwait();
    bus.i_scl = 1'b0; qwait();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; qwait();
    bus.i_scl = 1'b1; qwait();
    sda_m = 1'b1; qwait(); qwait();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; qwait();
    bus.i_scl = 1'b1; qwait(); qwait();
    bus.i_scl = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; qwait();
    bus.i_scl = 1'b1; qwait();
    ack = ~bus.i_sda;
    qwait();
    bus.i_scl = 1'b0; qwait();
  endtask

  task automatic model_commit(input logic [6:0] a, input logic [8:0] d);
    if (a == 7'd15) begin
      for (int i = 0; i <= 10; i++) mreg[i] = '0;
    end else if (a <= 7'd10) begin
      mreg[a[3:0]] = d;
    end
  endtask

  task automatic readback(input logic [3:0] idx);
    logic [8:0] exp;
    bus.i_rd_addr = idx;
    repeat (3) @(negedge clk);
`ifdef I2C_RESP_REGFILE_EN
    exp = (idx <= 4'd10) ? mreg[idx] : 9'd0;
`else
    exp = 9'd0;
`endif
    check("rd_data", {23'd0, bus.o_rd_data}, {23'd0, exp});
  endtask

  // One frame from fb[]: nb full bytes, then np bits of fb[nb], then STOP
  // unless keep_open (the next frame's START becomes a repeated START).
  task automatic run_frame(input int nb, input int np, input bit keep_open);
    bit  dev, wr, ack;
    int  exp_acks, pr0;
    ev_t e;
    dev = (fb[0][7:1] == 7'h1A);
    wr  = ~fb[0][0];
    if (nb >= 1 && dev) begin
      if (!wr) begin
        e.is_err = 1'b1; e.addr = '0; e.data = '0;
        exp_q.push_back(e);
      end else if (nb >= 3) begin
        e.is_err = 1'b0; e.addr = fb[1][7:1]; e.data = {fb[1][0], fb[2]};
        exp_q.push_back(e);
        model_commit(e.addr, e.data);
        if (nb >= 4) begin
          e.is_err = 1'b1; e.addr = '0; e.data = '0;
          exp_q.push_back(e);
        end
      end else begin
        e.is_err = 1'b1; e.addr = '0; e.data = '0;
        exp_q.push_back(e);
      end
    end
    exp_acks = (dev && wr) ? ((nb < 3) ? nb : 3) : 0;
    pr0 = pull_rises;
    i2c_start();
    check("busy_after_start", {31'd0, bus.o_busy}, 32'd1);
    for (int i = 0; i < nb; i++) begin
      send_byte(fb[i], ack);
      check("ack_bit", {31'd0, ack}, {31'd0, (dev && wr && i < 3)});
    end
    for (int i = 0; i < np; i++) send_bit(fb[nb][7-i]);
    check("ack_count", pull_rises - pr0, exp_acks);
    if (!keep_open) begin
      i2c_stop();
      check("busy_after_stop", {31'd0, bus.o_busy}, 32'd0);
    end
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while (exp_q.size() != 0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    bit ack;
    int nb, np;
    bit open;
    for (int i = 0; i <= 10; i++) mreg[i] = '0;
    rst_n = 1'b0;
    bus.i_scl = 1'b1;
    sda_m = 1'b1;
    bus.i_rd_addr = '0;
    repeat (4) @(negedge clk);
    check("rst_sda_pull", {31'd0, bus.o_sda_pull}, 32'd0);
    check("rst_wr_valid", {31'd0, bus.o_wr_valid}, 32'd0);
    check("rst_wr_addr", {25'd0, bus.o_wr_addr}, 32'd0);
    check("rst_wr_data", {23'd0, bus.o_wr_data}, 32'd0);
    check("rst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("rst_err", {31'd0, bus.o_err}, 32'd0);
    check("rst_rd_data", {23'd0, bus.o_rd_data}, 32'd0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Directed frames.
    fb[0] = 8'h34; fb[1] = 8'h1E; fb[2] = 8'h00; run_frame(3, 0, 0);
    fb[0] = 8'h34; fb[1] = 8'h08; fb[2] = 8'h15; run_frame(3, 0, 0);
    readback(4'd4);
    fb[0] = 8'h36; fb[1] = 8'h12; fb[2] = 8'h34; run_frame(3, 0, 0);
    fb[0] = 8'h35; run_frame(1, 0, 0);
    fb[0] = 8'h34; fb[1] = 8'h0E; fb[2] = 8'h4F; fb[3] = 8'hAA; run_frame(4, 0, 0);
    readback(4'd7);
    fb[0] = 8'h34; fb[1] = 8'h0C; run_frame(1, 4, 1);
    fb[0] = 8'h34; fb[1] = 8'h0C; fb[2] = 8'h01; run_frame(3, 0, 0);
    readback(4'd6);
    drain("directed_drain");

    // Reset in the middle of BYTE2.
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h08, ack);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_wr_addr", {25'd0, bus.o_wr_addr}, 32'd0);
    check("midrst_wr_data", {23'd0, bus.o_wr_data}, 32'd0);
    check("midrst_busy", {31'd0, bus.o_busy}, 32'd0);
    check("midrst_sda_pull", {31'd0, bus.o_sda_pull}, 32'd0);
    check("midrst_rd_data", {23'd0, bus.o_rd_data}, 32'd0);
    for (int i = 0; i <= 10; i++) mreg[i] = '0;
    repeat (3) @(negedge clk);
    sda_m = 1'b1;
    qwait();
    bus.i_scl = 1'b1;
    qwait();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", {31'd0, bus.o_busy}, 32'd0);
    fb[0] = 8'h34; fb[1] = 8'h08; fb[2] = 8'h15; run_frame(3, 0, 0);
    readback(4'd4);

    // Randomized frames.
    for (int k = 0; k < 22; k++) begin
      case ($urandom_range(0, 7))
        0, 1, 2, 3: fb[0] = 8'h34;
        4:          fb[0] = 8'h35;
        default:    fb[0] = 8'($urandom);
      endcase
      for (int i = 1; i <= 7; i++) fb[i] = 8'($urandom);
      if ($urandom_range(0, 7) == 0) fb[1] = {7'd15, 1'($urandom)};
      else if ($urandom_range(0, 1) == 1) fb[1] = {3'd0, 4'($urandom_range(0, 10)), 1'($urandom)};
      nb = $urandom_range(0, 5);
      if (nb == 0 && $urandom_range(0, 1) == 1) nb = 3;
      np = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(1, 7);
      open = (k < 21) && ($urandom_range(0, 3) == 0);
      run_frame(nb, np, open);
      if (!open) readback(4'($urandom_range(0, 15)));
    end
    drain("random_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
